// File: rtl/iap2_challenge_buffer.sv
// Captures iAP2 Request Challenge Response bytes, qualifies them against the parser's
// RCR pulse and length, then streams the challenge over a valid/ready byte interface.
module iap2_challenge_buffer #(
    parameter int DEPTH       = 64,
    parameter int AW          = 6,
    parameter int TIMEOUT_CYC = 60000
) (
    input  logic        i_usb_user_clk,
    input  logic        i_rst,
    input  logic [15:0] i_iap2_rx_param_lenth,
    input  logic        i_iap2_rx_param_data_vld,
    input  logic [7:0]  i_iap2_rx_param_data,
    input  logic        i_iap2_rx_rcr,
    input  logic [7:0]  i_iap2_rx_packet_seq,
    input  logic        i_flush,
    output logic        o_chal_pending,
    output logic [15:0] o_chal_len,
    output logic [7:0]  o_chal_seq,
    output logic        o_chal_vld,
    output logic [7:0]  o_chal_data,
    output logic        o_chal_last,
    input  logic        i_chal_rdy,
    output logic        o_chal_done,
    output logic        o_chal_err,
    output logic        o_chal_ovf,
    output logic        o_chal_drop,
    output logic [1:0]  o_dbg_state
);

    // Stream handshake: a byte transfers on a rising clock edge where o_chal_vld && i_chal_rdy;
    // while o_chal_vld is high and i_chal_rdy low, o_chal_data/o_chal_last are held unchanged.

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_FILL   = 2'd1,
        S_LOAD   = 2'd2,
        S_STREAM = 2'd3
    } state_t;

    localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYC - 1);

    state_t          state, state_nxt;
    logic [AW:0]     cnt, cnt_nxt, cnt_upd;
    logic [AW-1:0]   rd_ptr, rd_ptr_inc;
    logic [15:0]     tmo, tmo_nxt;
    logic [15:0]     rd_ptr_ext;
    logic [7:0]      mem [DEPTH];
    logic            wr_en;
    logic [AW-1:0]   wr_addr;
    logic            ovf_nxt, ovf_upd;
    logic            qualify, err_nxt, drop_nxt, finish, hs;

    assign hs          = o_chal_vld && i_chal_rdy;
    assign rd_ptr_inc  = rd_ptr + AW'(1);
    assign rd_ptr_ext  = {{(16-AW){1'b0}}, rd_ptr};
    assign o_chal_last = o_chal_vld && (rd_ptr_ext == o_chal_len - 16'd1);
    assign o_dbg_state = state;

    // A byte arriving with the RCR pulse is counted before qualification.
    assign cnt_upd = (i_iap2_rx_param_data_vld && cnt < CNT_FULL) ? cnt + (AW+1)'(1) : cnt;
    assign ovf_upd = o_chal_ovf || (i_iap2_rx_param_data_vld && cnt == CNT_FULL);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        tmo_nxt   = tmo;
        ovf_nxt   = o_chal_ovf;
        wr_en     = 1'b0;
        wr_addr   = cnt[AW-1:0];
        qualify   = 1'b0;
        err_nxt   = 1'b0;
        drop_nxt  = 1'b0;
        finish    = 1'b0;
        case (state)
            S_IDLE: begin
                if (i_iap2_rx_param_data_vld) begin
                    wr_en     = 1'b1;
                    wr_addr   = '0;
                    cnt_nxt   = (AW+1)'(1);
                    ovf_nxt   = 1'b0;
                    tmo_nxt   = '0;
                    state_nxt = S_FILL;
                end else if (i_iap2_rx_rcr) begin
                    err_nxt = 1'b1;
                end
            end
            S_FILL: begin
                if (i_iap2_rx_param_data_vld) begin
                    tmo_nxt = '0;
                    wr_en   = (cnt < CNT_FULL);
                    cnt_nxt = cnt_upd;
                    ovf_nxt = ovf_upd;
                end
                if (i_iap2_rx_rcr) begin
                    if (i_iap2_rx_param_lenth == {{(15-AW){1'b0}}, cnt_upd} && !ovf_upd &&
                        cnt_upd != '0) begin
                        qualify   = 1'b1;
                        state_nxt = S_LOAD;
                    end else begin
                        err_nxt   = 1'b1;
                        cnt_nxt   = '0;
                        state_nxt = S_IDLE;
                    end
                end else if (!i_iap2_rx_param_data_vld) begin
                    if (tmo == TMO_LAST) begin
                        err_nxt   = 1'b1;
                        cnt_nxt   = '0;
                        tmo_nxt   = '0;
                        state_nxt = S_IDLE;
                    end else begin
                        tmo_nxt = tmo + 16'd1;
                    end
                end
            end
            S_LOAD: begin
                drop_nxt  = i_iap2_rx_param_data_vld;
                state_nxt = S_STREAM;
            end
            S_STREAM: begin
                drop_nxt = i_iap2_rx_param_data_vld;
                if (hs && o_chal_last) begin
                    finish    = 1'b1;
                    cnt_nxt   = '0;
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_usb_user_clk) begin
        if (wr_en && !i_rst && !i_flush) begin
            mem[wr_addr] <= i_iap2_rx_param_data;
        end
    end

    always_ff @(posedge i_usb_user_clk) begin
        if (i_rst || i_flush) begin
            state          <= S_IDLE;
            cnt            <= '0;
            rd_ptr         <= '0;
            tmo            <= '0;
            o_chal_pending <= 1'b0;
            o_chal_vld     <= 1'b0;
            o_chal_data    <= '0;
            o_chal_done    <= 1'b0;
            o_chal_err     <= 1'b0;
            o_chal_ovf     <= 1'b0;
            o_chal_drop    <= 1'b0;
            if (i_rst) begin
                o_chal_len <= '0;
                o_chal_seq <= '0;
            end
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            tmo         <= tmo_nxt;
            o_chal_ovf  <= ovf_nxt;
            o_chal_err  <= err_nxt;
            o_chal_drop <= drop_nxt;
            o_chal_done <= finish;
            if (qualify) begin
                o_chal_len     <= {{(15-AW){1'b0}}, cnt_upd};
                o_chal_seq     <= i_iap2_rx_packet_seq;
                o_chal_pending <= 1'b1;
                rd_ptr         <= '0;
            end
            if (state == S_LOAD) begin
                o_chal_data <= mem[rd_ptr];
                o_chal_vld  <= 1'b1;
            end
            // Prefetch the following byte on each accepted non-last byte for 1 byte/cycle.
            if (state == S_STREAM && hs) begin
                if (o_chal_last) begin
                    o_chal_vld     <= 1'b0;
                    o_chal_pending <= 1'b0;
                end else begin
                    rd_ptr      <= rd_ptr_inc;
                    o_chal_data <= mem[rd_ptr_inc];
                end
            end
        end
    end

endmodule
